pe_inject_scheduler: RTL and testbench

PE_INJECT_SCHEDULER -- requirements
Module: pe_inject_scheduler

---
 rtl/pe_inject_scheduler_pkg.sv | 19 +
 rtl/pe_inject_scheduler_rr_grant.sv | 28 ++
 rtl/pe_inject_scheduler.sv | 125 ++++++++++++
 tb/tb_pe_inject_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pe_inject_scheduler_pkg.sv
// Shared types and constants for the PE injection scheduler.
package pe_inject_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INJECT = 2'd1,
        LOOP   = 2'd2
    } state_e;

    // Destination coordinate fields, counted in units of ADDRESS_WIDTH from bit 0.
    localparam int X_FIELD = 0;
    localparam int Y_FIELD = 1;
    localparam int Z_FIELD = 2;

    function automatic int field_lsb(input int field, input int addr_width);
        return field * addr_width;
    endfunction

endpackage

// File: rtl/pe_inject_scheduler_rr_grant.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_grant #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic found;
    int   idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_inject_scheduler.sv
// Local flit injection scheduler: arbitrates requesters into a holding register,
// then drives the router port or the loopback port. Optional stats: PE_INJECT_STATS_EN.
module pe_inject_scheduler
    import pe_inject_scheduler_pkg::*;
#(
    parameter int FLIT_SIZE     = 128,
    parameter int ADDRESS_WIDTH = 3,
    parameter int CUR_X         = 0,
    parameter int CUR_Y         = 0,
    parameter int CUR_Z         = 0,
    parameter int NUM_REQ       = 4,
    parameter int STALL_LIMIT   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FLIT_SIZE-1:0]  req_flit,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          pe_in_valid,
    output logic [FLIT_SIZE-1:0]          pe_input,
    input  logic                          injection_success,
    output logic                          lb_valid,
    output logic [FLIT_SIZE-1:0]          lb_flit,
    input  logic                          lb_ready,
    output logic                          stall_alarm
`ifdef PE_INJECT_STATS_EN
    ,
    output logic [31:0]                   inj_count,
    output logic [31:0]                   lb_count,
    output logic [31:0]                   fail_total
`endif
);

    localparam int PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = ADDRESS_WIDTH;
    localparam int X_LSB = field_lsb(X_FIELD, ADDRESS_WIDTH);
    localparam int Y_LSB = field_lsb(Y_FIELD, ADDRESS_WIDTH);
    localparam int Z_LSB = field_lsb(Z_FIELD, ADDRESS_WIDTH);

    state_e                 state, state_nxt;
    logic [FLIT_SIZE-1:0]   hold;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          g_idx;
    logic [NUM_REQ-1:0]     grant;
    logic [FLIT_SIZE-1:0]   sel;
    logic [7:0]             fail_cnt, fail_nxt;
    logic                   consume, take, self_dst;

    rr_grant #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        g_idx = '0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx = PW'(i);
                sel   = req_flit[i*FLIT_SIZE +: FLIT_SIZE];
            end
        end
    end

    assign self_dst = (sel[X_LSB +: AW] == AW'(CUR_X)) &&
                      (sel[Y_LSB +: AW] == AW'(CUR_Y)) &&
                      (sel[Z_LSB +: AW] == AW'(CUR_Z));

    // A consume cycle doubles as a grant cycle so flits stream one per clock.
    always_comb begin
        consume   = (state == INJECT && injection_success) || (state == LOOP && lb_ready);
        take      = !rst && (state == IDLE || consume) && (|req_valid);
        req_ready = take ? grant : '0;
        state_nxt = state;
        if (take)         state_nxt = self_dst ? LOOP : INJECT;
        else if (consume) state_nxt = IDLE;
        fail_nxt = fail_cnt;
        if (state == INJECT) begin
            if (injection_success)      fail_nxt = '0;
            else if (fail_cnt != 8'hFF) fail_nxt = fail_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold        <= '0;
            ptr         <= '0;
            fail_cnt    <= '0;
            stall_alarm <= 1'b0;
        end else begin
            fail_cnt    <= fail_nxt;
            stall_alarm <= (fail_nxt >= 8'(STALL_LIMIT));
            if (take) begin
                hold <= sel;
                ptr  <= (g_idx == PW'(NUM_REQ-1)) ? '0 : g_idx + 1'b1;
            end
        end
    end

    assign pe_in_valid = (state == INJECT);
    assign pe_input    = pe_in_valid ? hold : '0;
    assign lb_valid    = (state == LOOP);
    assign lb_flit     = lb_valid ? hold : '0;

`ifdef PE_INJECT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inj_count  <= '0;
            lb_count   <= '0;
            fail_total <= '0;
        end else begin
            if (state == INJECT && injection_success)  inj_count  <= inj_count + 32'd1;
            if (state == LOOP && lb_ready)             lb_count   <= lb_count + 32'd1;
            if (state == INJECT && !injection_success) fail_total <= fail_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pe_inject_scheduler.sv
// Randomized bench for pe_inject_scheduler against a transaction-level model.
module tb_pe_inject_scheduler;

    localparam int FS = 128;
    localparam int AW = 3;
    localparam int NR = 4;
    localparam int SL = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*FS-1:0]  req_flit;
    logic              pe_in_valid, injection_success, lb_valid, lb_ready, stall_alarm;
    logic [FS-1:0]     pe_input, lb_flit;
`ifdef PE_INJECT_STATS_EN
    logic [31:0]       inj_count, lb_count, fail_total;
`endif

    pe_inject_scheduler #(
        .FLIT_SIZE(FS), .ADDRESS_WIDTH(AW), .CUR_X(0), .CUR_Y(0), .CUR_Z(0),
        .NUM_REQ(NR), .STALL_LIMIT(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_flit(req_flit), .req_ready(req_ready),
        .pe_in_valid(pe_in_valid), .pe_input(pe_input),
        .injection_success(injection_success),
        .lb_valid(lb_valid), .lb_flit(lb_flit), .lb_ready(lb_ready),
        .stall_alarm(stall_alarm)
`ifdef PE_INJECT_STATS_EN
        , .inj_count(inj_count), .lb_count(lb_count), .fail_total(fail_total)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // staged stimulus, applied at the next falling edge
    logic              s_rst;
    logic [NR-1:0]     s_vld;
    logic [NR*FS-1:0]  s_flit;
    logic              s_succ, s_lbr;

    // model: a single-entry buffer plus a "next requester to consider" index
    bit            m_known = 0;
    bit            m_has, m_local, m_alarm;
    logic [FS-1:0] m_flit;
    int            m_ptr, m_fail;
    int            alarm_cycles = 0;

    task automatic chk(input string tag, input logic [FS-1:0] obs, input logic [FS-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FS-1:0] make_flit(input bit self);
        logic [FS-1:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        if (self) f[3*AW-1:0] = '0;
        else if (f[3*AW-1:0] == '0) f[0] = 1'b1;
        return f;
    endfunction

    task automatic step();
        int            g;
        bit            cons;
        logic [NR-1:0] e_rdy;
        @(negedge clk);
        rst = s_rst; req_valid = s_vld; req_flit = s_flit;
        injection_success = s_succ; lb_ready = s_lbr;
        #1;
        g     = -1;
        cons  = m_has && (m_local ? s_lbr : s_succ);
        if (!s_rst && (!m_has || cons))
            for (int k = 0; k < NR; k++)
                if (g < 0 && s_vld[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        e_rdy = (g >= 0) ? NR'(1 << g) : '0;
        chk("req_ready", req_ready, e_rdy);
        if (m_known) begin
            chk("pe_in_valid", pe_in_valid, m_has && !m_local);
            chk("pe_input", pe_input, (m_has && !m_local) ? m_flit : '0);
            chk("lb_valid", lb_valid, m_has && m_local);
            chk("lb_flit", lb_flit, (m_has && m_local) ? m_flit : '0);
            chk("stall_alarm", stall_alarm, m_alarm);
            if (stall_alarm === 1'b1) alarm_cycles++;
        end
        if (s_rst) begin
            m_known = 1; m_has = 0; m_local = 0; m_ptr = 0; m_fail = 0; m_alarm = 0;
            m_flit = '0;
        end else begin
            if (m_has && !m_local) m_fail = s_succ ? 0 : ((m_fail < 255) ? m_fail + 1 : 255);
            m_alarm = (m_fail >= SL);
            if (g >= 0) begin
                m_flit  = s_flit[g*FS +: FS];
                m_local = (m_flit[3*AW-1:0] == '0);
                m_has   = 1;
                m_ptr   = (g + 1) % NR;
            end else if (cons) begin
                m_has = 0;
            end
        end
    endtask

    task automatic set_stim(input logic r, input logic [NR-1:0] v, input bit self,
                            input logic sc, input logic lb);
        s_rst = r; s_vld = v; s_succ = sc; s_lbr = lb;
        for (int i = 0; i < NR; i++) s_flit[i*FS +: FS] = make_flit(self);
    endtask

    task automatic drain();
        set_stim(0, '0, 0, 1, 1);
        repeat (2) step();
    endtask

    initial begin
        rst = 1; req_valid = '0; req_flit = '0; injection_success = 0; lb_ready = 0;
        set_stim(1, '0, 0, 0, 0);
        repeat (2) step();

        // single requester, remote destination, router always accepts
        set_stim(0, 4'b0001, 0, 1, 1);
        step();
        set_stim(0, '0, 0, 1, 1);
        repeat (2) step();

        // all requesters streaming back-to-back
        set_stim(0, 4'b1111, 0, 1, 1);
        repeat (9) step();
        drain();

        // long stall on one held flit, then success
        set_stim(0, 4'b0100, 0, 0, 1);
        step();
        set_stim(0, '0, 0, 0, 1);
        repeat (20) step();
        set_stim(0, '0, 0, 1, 1);
        repeat (3) step();
        chk("alarm_seen", alarm_cycles > 0, 1'b1);

        // self-addressed flit waits on loopback
        set_stim(0, 4'b0010, 1, 1, 0);
        step();
        set_stim(0, '0, 1, 1, 0);
        repeat (3) step();
        set_stim(0, '0, 1, 1, 1);
        repeat (2) step();

        // reset in the middle of an injection
        set_stim(0, 4'b0100, 0, 0, 1);
        step();
        set_stim(0, '0, 0, 0, 1);
        repeat (2) step();
        set_stim(1, 4'b1111, 0, 0, 1);
        step();
        set_stim(0, 4'b1111, 0, 1, 1);
        repeat (5) step();
        drain();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            s_rst  = ($urandom_range(0, 199) == 0);
            s_vld  = NR'($urandom);
            s_succ = ($urandom_range(0, 3) != 0);
            s_lbr  = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < NR; i++) s_flit[i*FS +: FS] = make_flit($urandom_range(0, 2) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
